ex_complete: RTL and testbench

Execute/complete-side counterpart of the reservation station: accepts one issued instruction per cycle, carries its tag through a 1-cycle ALU slot or a pipelined multiplier, arbitrates finished instructions onto the single CDB, and returns the RS slot-release (`remove_en`/`remove_idx`) to the reservation station. A small completion buffer absorbs CDB contention. Issue backpressure is credit-based, so the buffer never overflows. Tags only; operand/result datapaths live in the FUs.

---
 rtl/sys_defs.sv | 25 ++
 rtl/cbuf_fifo.sv | 54 +++++
 rtl/ex_complete.sv | 134 +++++++++++++
 tb/tb_ex_complete.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_defs.sv
// Shared execute-side types: RS slot packet, CDB tag, and the tag-only op record
// carried through the ALU slot, multiplier pipe and completion buffer.
package sys_defs;

  localparam int unsigned DEF_RS_SZ      = 5;
  localparam int unsigned DEF_IDX_W      = $clog2(DEF_RS_SZ);
  localparam int unsigned DEF_PREG_W     = 6;
  localparam int unsigned DEF_MUL_LAT    = 4;
  localparam int unsigned DEF_CBUF_DEPTH = 4;

  typedef logic [DEF_PREG_W-1:0] TAG;

  typedef struct packed {
    logic                 valid;
    logic [DEF_IDX_W-1:0] idx;
  } EX_RS_PACKET;

  typedef struct packed {
    logic                 valid;
    logic [DEF_IDX_W-1:0] rs_idx;
    TAG                   preg;
    logic                 dest_valid;
  } EX_OP;

endpackage

// File: rtl/cbuf_fifo.sv
// Completion buffer: circular FIFO accepting up to two pushes (push0 first)
// and one pop per cycle; occupancy is exported for issue credit.
module cbuf_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter type T = logic [7:0]
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push0_en,
  input  T                       push0_data,
  input  logic                   push1_en,
  input  T                       push1_data,
  input  logic                   pop_en,
  output T                       head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr_nxt;
  logic [1:0]       n_push;

  assign wr_ptr_nxt = wr_ptr + PTR_W'(1);
  assign n_push     = 2'(push0_en) + 2'(push1_en);
  assign head       = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(n_push);
      if (pop_en) rd_ptr <= rd_ptr + PTR_W'(1);
      count  <= count + CNT_W'(n_push) - CNT_W'(pop_en);
    end
  end

  always_ff @(posedge clk) begin
    if (push0_en) mem[wr_ptr] <= push0_data;
    if (push1_en) mem[push0_en ? wr_ptr_nxt : wr_ptr] <= push1_data;
  end

endmodule

// File: rtl/ex_complete.sv
// Execute/complete stage: routes issued tags through a 1-cycle ALU slot or a
// pipelined multiplier, arbitrates completions onto the CDB and frees RS slots.
module ex_complete
  import sys_defs::*;
#(
  parameter int unsigned RS_SZ      = DEF_RS_SZ,
  localparam int unsigned IDX_W     = $clog2(RS_SZ),
  parameter int unsigned PREG_W     = DEF_PREG_W,
  parameter int unsigned MUL_LAT    = DEF_MUL_LAT,
  parameter int unsigned CBUF_DEPTH = DEF_CBUF_DEPTH
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              interrupt,
  input  logic              issue_en,
  input  logic [IDX_W-1:0]  issue_rs_idx,
  input  logic [PREG_W-1:0] issue_dest_preg,
  input  logic              issue_dest_valid,
  input  logic              issue_is_mult,
  output logic              issue_ready,
  output logic              cdb_en,
  output logic [PREG_W-1:0] cdb_preg,
  output logic              remove_en,
  output logic [IDX_W-1:0]  remove_idx
);

  localparam int unsigned CNT_W  = $clog2(CBUF_DEPTH) + 1;
  localparam int unsigned CRED_W = $clog2(CBUF_DEPTH + MUL_LAT + 1) + 1;

  EX_OP              alu_op;
  EX_OP              mul_pipe [MUL_LAT];
  EX_OP              new_op;
  EX_OP              mul_out;
  EX_OP              head_op;
  EX_OP              grant;
  EX_RS_PACKET       rm_pkt;
  TAG                cdb_tag;
  logic              accept;
  logic              buf_valid;
  logic              pop;
  logic              push_mul;
  logic              push_alu;
  logic [CNT_W-1:0]  buf_count;
  logic [CRED_W-1:0] credit;

  // Every op in flight reserves one buffer slot, so the buffer can never overflow
  always_comb begin
    credit = CRED_W'(buf_count) + CRED_W'(alu_op.valid);
    for (int i = 0; i < MUL_LAT; i++) credit = credit + CRED_W'(mul_pipe[i].valid);
  end

  assign issue_ready = credit < CRED_W'(CBUF_DEPTH);
  assign accept      = issue_en && issue_ready && !interrupt;

  always_comb begin
    new_op            = '0;
    new_op.valid      = 1'b1;
    new_op.rs_idx     = DEF_IDX_W'(issue_rs_idx);
    new_op.preg       = TAG'(issue_dest_preg);
    new_op.dest_valid = issue_dest_valid;
  end

  // Fixed priority: buffer head, then multiplier output, then ALU output
  always_comb begin
    mul_out   = mul_pipe[MUL_LAT-1];
    buf_valid = buf_count != '0;
    grant     = '0;
    pop       = 1'b0;
    if (buf_valid) begin
      grant = head_op;
      pop   = 1'b1;
    end else if (mul_out.valid) begin
      grant = mul_out;
    end else if (alu_op.valid) begin
      grant = alu_op;
    end
    push_mul = mul_out.valid && buf_valid;
    push_alu = alu_op.valid && (buf_valid || mul_out.valid);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      alu_op <= '0;
      for (int i = 0; i < MUL_LAT; i++) mul_pipe[i] <= '0;
    end else if (interrupt) begin
      alu_op <= '0;
      for (int i = 0; i < MUL_LAT; i++) mul_pipe[i] <= '0;
    end else begin
      alu_op      <= (accept && !issue_is_mult) ? new_op : '0;
      mul_pipe[0] <= (accept && issue_is_mult) ? new_op : '0;
      for (int i = 1; i < MUL_LAT; i++) mul_pipe[i] <= mul_pipe[i-1];
    end
  end

  // Tag and index hold their last value when nothing is granted
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rm_pkt  <= '0;
      cdb_en  <= 1'b0;
      cdb_tag <= '0;
    end else if (interrupt) begin
      rm_pkt.valid <= 1'b0;
      cdb_en       <= 1'b0;
    end else begin
      rm_pkt.valid <= grant.valid;
      cdb_en       <= grant.valid && grant.dest_valid;
      if (grant.valid) begin
        rm_pkt.idx <= grant.rs_idx;
        cdb_tag    <= grant.preg;
      end
    end
  end

  assign remove_en  = rm_pkt.valid;
  assign remove_idx = IDX_W'(rm_pkt.idx);
  assign cdb_preg   = PREG_W'(cdb_tag);

  cbuf_fifo #(
    .DEPTH (CBUF_DEPTH),
    .T     (EX_OP)
  ) u_cbuf (
    .clk        (clock),
    .rst_n      (reset),
    .flush      (interrupt),
    .push0_en   (push_mul),
    .push0_data (mul_out),
    .push1_en   (push_alu),
    .push1_data (alu_op),
    .pop_en     (pop),
    .head       (head_op),
    .count      (buf_count)
  );

endmodule

// File: tb/tb_ex_complete.sv
// Bench for ex_complete: per-FU scoreboard queues filled on accepted issue,
// drained on remove_en; issue credit modelled from outstanding op count.
module tb_ex_complete;

  localparam int unsigned IDX_W   = 3;
  localparam int unsigned PREG_W  = 6;
  localparam int unsigned MUL_LAT = 4;
  localparam int unsigned DEPTH   = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              interrupt = 1'b0;
  logic              issue_en = 1'b0;
  logic [IDX_W-1:0]  issue_rs_idx = '0;
  logic [PREG_W-1:0] issue_dest_preg = '0;
  logic              issue_dest_valid = 1'b0;
  logic              issue_is_mult = 1'b0;
  logic              issue_ready;
  logic              cdb_en;
  logic [PREG_W-1:0] cdb_preg;
  logic              remove_en;
  logic [IDX_W-1:0]  remove_idx;

  always #5 clock = ~clock;

  ex_complete dut (
    .clock            (clock),
    .reset            (reset),
    .interrupt        (interrupt),
    .issue_en         (issue_en),
    .issue_rs_idx     (issue_rs_idx),
    .issue_dest_preg  (issue_dest_preg),
    .issue_dest_valid (issue_dest_valid),
    .issue_is_mult    (issue_is_mult),
    .issue_ready      (issue_ready),
    .cdb_en           (cdb_en),
    .cdb_preg         (cdb_preg),
    .remove_en        (remove_en),
    .remove_idx       (remove_idx)
  );

  typedef struct {
    logic [IDX_W-1:0]  idx;
    logic [PREG_W-1:0] preg;
    logic              dv;
  } rec_t;

  rec_t mul_q[$];
  rec_t alu_q[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   rm_cnt = 0;
  int   outstanding = 0;
  logic mon_on = 1'b0;
  logic p_acc = 1'b0;
  logic p_flush = 1'b0;
  logic p_mul = 1'b0;
  rec_t p_rec;

  // Inputs are stable at the falling edge; capture what the next rising edge sees
  always @(negedge clock) begin
    p_acc      = reset && !interrupt && issue_en && issue_ready;
    p_flush    = !reset || interrupt;
    p_mul      = issue_is_mult;
    p_rec.idx  = issue_rs_idx;
    p_rec.preg = issue_dest_preg;
    p_rec.dv   = issue_dest_valid;
  end

  always @(posedge clock) begin
    #1;
    if (mon_on) begin
      if (p_flush) begin
        mul_q.delete();
        alu_q.delete();
        outstanding = 0;
      end
      total_cnt++;
      if (remove_en === 1'b1) begin
        logic matched;
        matched = 1'b0;
        rm_cnt++;
        outstanding--;
        if (mul_q.size() > 0 && mul_q[0].idx == remove_idx && mul_q[0].dv == cdb_en &&
            (!mul_q[0].dv || mul_q[0].preg == cdb_preg)) begin
          void'(mul_q.pop_front());
          matched = 1'b1;
        end else if (alu_q.size() > 0 && alu_q[0].idx == remove_idx && alu_q[0].dv == cdb_en &&
                     (!alu_q[0].dv || alu_q[0].preg == cdb_preg)) begin
          void'(alu_q.pop_front());
          matched = 1'b1;
        end
        if (matched) pass_cnt++;
        else $display("FAIL scoreboard: got remove idx=%0d cdb_en=%b preg=%0d, want head of mul_q(%0d) or alu_q(%0d)",
                      remove_idx, cdb_en, cdb_preg, mul_q.size(), alu_q.size());
      end else if (cdb_en !== 1'b0) begin
        $display("FAIL cdb_without_remove: got cdb_en=%b remove_en=%b, want cdb_en=0", cdb_en, remove_en);
      end else begin
        pass_cnt++;
      end
      if (p_acc) begin
        if (p_mul) mul_q.push_back(p_rec);
        else       alu_q.push_back(p_rec);
        outstanding++;
      end
      total_cnt++;
      if (issue_ready !== (outstanding < DEPTH))
        $display("FAIL issue_credit: got issue_ready=%b, want %b (outstanding=%0d)",
                 issue_ready, outstanding < DEPTH, outstanding);
      else pass_cnt++;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic en, input logic mul, input int idx, input int preg, input logic dv);
    issue_en         = en;
    issue_is_mult    = mul;
    issue_rs_idx     = IDX_W'(idx);
    issue_dest_preg  = PREG_W'(preg);
    issue_dest_valid = dv;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) step();
    total_cnt++; if (cdb_en !== 1'b0) $display("FAIL reset_cdb_en: got %b want 0", cdb_en); else pass_cnt++;
    total_cnt++; if (remove_en !== 1'b0) $display("FAIL reset_remove_en: got %b want 0", remove_en); else pass_cnt++;
    total_cnt++; if (cdb_preg !== '0) $display("FAIL reset_cdb_preg: got %0d want 0", cdb_preg); else pass_cnt++;
    total_cnt++; if (remove_idx !== '0) $display("FAIL reset_remove_idx: got %0d want 0", remove_idx); else pass_cnt++;
    total_cnt++; if (issue_ready !== 1'b1) $display("FAIL reset_issue_ready: got %b want 1", issue_ready); else pass_cnt++;
    reset  = 1'b1;
    mon_on = 1'b1;
  endtask

  task automatic test_alu();
    drive(1'b1, 1'b0, 3, 17, 1'b1);
    step();
    drive(1'b0, 1'b0, 0, 0, 1'b0);
    total_cnt++; if (cdb_en !== 1'b0) $display("FAIL alu_early: got cdb_en=%b want 0", cdb_en); else pass_cnt++;
    step();
    total_cnt++; if (cdb_en !== 1'b1) $display("FAIL alu_cdb_en: got %b want 1", cdb_en); else pass_cnt++;
    total_cnt++; if (cdb_preg !== 6'd17) $display("FAIL alu_cdb_preg: got %0d want 17", cdb_preg); else pass_cnt++;
    total_cnt++; if (remove_en !== 1'b1) $display("FAIL alu_remove_en: got %b want 1", remove_en); else pass_cnt++;
    total_cnt++; if (remove_idx !== 3'd3) $display("FAIL alu_remove_idx: got %0d want 3", remove_idx); else pass_cnt++;
    step();
    total_cnt++; if (remove_en !== 1'b0 || cdb_en !== 1'b0)
      $display("FAIL alu_one_cycle: got remove_en=%b cdb_en=%b want 0 0", remove_en, cdb_en); else pass_cnt++;
  endtask

  task automatic test_contention();
    drive(1'b1, 1'b1, 0, 5, 1'b1);
    step();
    drive(1'b0, 1'b0, 0, 0, 1'b0);
    repeat (MUL_LAT - 2) step();
    drive(1'b1, 1'b0, 4, 9, 1'b1);
    step();
    drive(1'b0, 1'b0, 0, 0, 1'b0);
    step();
    total_cnt++; if (cdb_en !== 1'b1 || cdb_preg !== 6'd5 || remove_idx !== 3'd0)
      $display("FAIL contend_mul_first: got cdb_en=%b preg=%0d idx=%0d want 1 5 0", cdb_en, cdb_preg, remove_idx); else pass_cnt++;
    step();
    total_cnt++; if (cdb_en !== 1'b1 || cdb_preg !== 6'd9 || remove_idx !== 3'd4)
      $display("FAIL contend_alu_next: got cdb_en=%b preg=%0d idx=%0d want 1 9 4", cdb_en, cdb_preg, remove_idx); else pass_cnt++;
    step();
    total_cnt++; if (remove_en !== 1'b0) $display("FAIL contend_idle: got remove_en=%b want 0", remove_en); else pass_cnt++;
  endtask

  task automatic test_store();
    drive(1'b1, 1'b0, 2, 33, 1'b0);
    step();
    drive(1'b0, 1'b0, 0, 0, 1'b0);
    step();
    total_cnt++; if (remove_en !== 1'b1 || remove_idx !== 3'd2)
      $display("FAIL store_remove: got remove_en=%b idx=%0d want 1 2", remove_en, remove_idx); else pass_cnt++;
    total_cnt++; if (cdb_en !== 1'b0) $display("FAIL store_no_cdb: got cdb_en=%b want 0", cdb_en); else pass_cnt++;
    step();
  endtask

  task automatic test_back_to_back();
    int   issued;
    int   rm0;
    logic saw_stall;
    logic rdy;
    issued    = 0;
    rm0       = rm_cnt;
    saw_stall = 1'b0;
    for (int cyc = 0; cyc < 200 && issued < 20; cyc++) begin
      drive(1'b1, (issued < 6) || (issued % 2 == 0), issued % 5, 20 + issued, 1'b1);
      rdy = issue_ready;
      step();
      if (rdy) issued++;
      else saw_stall = 1'b1;
    end
    drive(1'b0, 1'b0, 0, 0, 1'b0);
    for (int cyc = 0; cyc < 60 && (mul_q.size() + alu_q.size()) > 0; cyc++) step();
    step();
    total_cnt++; if (issued != 20) $display("FAIL b2b_issued: got %0d want 20", issued); else pass_cnt++;
    total_cnt++; if (mul_q.size() + alu_q.size() != 0)
      $display("FAIL b2b_drain: got %0d ops pending want 0", mul_q.size() + alu_q.size()); else pass_cnt++;
    total_cnt++; if (rm_cnt - rm0 != 20) $display("FAIL b2b_removes: got %0d want 20", rm_cnt - rm0); else pass_cnt++;
    total_cnt++; if (saw_stall !== 1'b1) $display("FAIL b2b_stall: got %b want 1", saw_stall); else pass_cnt++;
  endtask

  task automatic test_interrupt();
    int rm0;
    drive(1'b1, 1'b1, 0, 50, 1'b1); step();
    drive(1'b1, 1'b1, 1, 51, 1'b1); step();
    drive(1'b1, 1'b1, 2, 52, 1'b1); step();
    drive(1'b1, 1'b0, 3, 53, 1'b1); step();
    drive(1'b0, 1'b0, 0, 0, 1'b0);  step();
    total_cnt++; if (cdb_en !== 1'b1 || cdb_preg !== 6'd50)
      $display("FAIL intr_inflight: got cdb_en=%b preg=%0d want 1 50", cdb_en, cdb_preg); else pass_cnt++;
    drive(1'b1, 1'b0, 4, 54, 1'b1);
    interrupt = 1'b1;
    step();
    interrupt = 1'b0;
    drive(1'b0, 1'b0, 0, 0, 1'b0);
    total_cnt++; if (cdb_en !== 1'b0 || remove_en !== 1'b0)
      $display("FAIL intr_outputs: got cdb_en=%b remove_en=%b want 0 0", cdb_en, remove_en); else pass_cnt++;
    total_cnt++; if (issue_ready !== 1'b1) $display("FAIL intr_ready: got %b want 1", issue_ready); else pass_cnt++;
    rm0 = rm_cnt;
    repeat (10) step();
    total_cnt++; if (rm_cnt != rm0) $display("FAIL intr_silence: got %0d removes want 0", rm_cnt - rm0); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b0, 1, 40, 1'b1);
    step();
    drive(1'b0, 1'b0, 0, 0, 1'b0);
    step();
    total_cnt++; if (cdb_en !== 1'b1 || cdb_preg !== 6'd40)
      $display("FAIL rst_mid_bcast: got cdb_en=%b preg=%0d want 1 40", cdb_en, cdb_preg); else pass_cnt++;
    #2;
    reset = 1'b0;
    #1;
    total_cnt++; if (cdb_en !== 1'b0 || remove_en !== 1'b0)
      $display("FAIL rst_async: got cdb_en=%b remove_en=%b want 0 0", cdb_en, remove_en); else pass_cnt++;
    step();
    reset = 1'b1;
    drive(1'b1, 1'b0, 2, 41, 1'b1);
    step();
    drive(1'b0, 1'b0, 0, 0, 1'b0);
    total_cnt++; if (cdb_en !== 1'b0) $display("FAIL rst_post_early: got cdb_en=%b want 0", cdb_en); else pass_cnt++;
    step();
    total_cnt++; if (cdb_en !== 1'b1 || cdb_preg !== 6'd41 || remove_idx !== 3'd2)
      $display("FAIL rst_post_alu: got cdb_en=%b preg=%0d idx=%0d want 1 41 2", cdb_en, cdb_preg, remove_idx); else pass_cnt++;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_alu();
    test_contention();
    test_store();
    test_back_to_back();
    test_interrupt();
    test_reset_mid();
    repeat (3) step();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
